multicycle_control: RTL and testbench

//  Multi-cycle MIPS main control FSM with integrated ALU decode. Successor to the

---
 rtl/multicycle_control.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with built-in ALU decode, memory ready
// handshake with timeout, and a sticky trap state for illegal encodings.
module multicycle_control #(
  parameter bit EXT_IMM     = 1'b1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       trap,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam int             TO_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_state;
  logic             funct_ok;
  logic [2:0]       funct_alu;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_AND;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    trap       = 1'b0;
    wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        case (op)
          OP_RTYPE:                  state_d = funct_ok ? S_EXEC : S_TRAP;
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_BEQ:                    state_d = S_BRANCH;
          OP_J:                      state_d = S_JUMP;
          OP_ADDI:                   state_d = S_IMMEX;
          OP_ANDI, OP_ORI, OP_SLTI:  state_d = EXT_IMM ? S_IMMEX : S_TRAP;
          default:                   state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = zero;
        state_d   = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op)
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORI:  alu_ctrl = ALU_OR;
          OP_SLTI: alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
    endcase

    // a late mem_ready still completes the access; only a silent last cycle traps
    if ((MEM_TIMEOUT > 0) && wait_state && !mem_ready && (cnt_q == TO_LAST)) begin
      state_d = S_TRAP;
    end

    if (wait_state && !mem_ready && (state_d == state_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    state_o = state_q;

    if (reset) begin
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 3'b000;
      pc_src     = 2'b00;
      pc_en      = 1'b0;
      trap       = 1'b0;
      state_o    = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle scoreboard bench: two instances (default params, and
// EXT_IMM=0 / MEM_TIMEOUT=4) share stimulus; per-cycle expectations are queued.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, zero, mem_ready;
  logic [5:0] op, funct;

  logic       iord_a, mem_read_a, mem_write_a, ir_write_a, reg_dst_a, mem_to_reg_a, reg_write_a, alu_src_a_a;
  logic [1:0] alu_src_b_a, pc_src_a;
  logic [2:0] alu_ctrl_a;
  logic       pc_en_a, trap_a;
  logic [3:0] state_a;
  logic       iord_b, mem_read_b, mem_write_b, ir_write_b, reg_dst_b, mem_to_reg_b, reg_write_b, alu_src_a_b;
  logic [1:0] alu_src_b_b, pc_src_b;
  logic [2:0] alu_ctrl_b;
  logic       pc_en_b, trap_b;
  logic [3:0] state_b;

  multicycle_control dut_a (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord_a), .mem_read(mem_read_a), .mem_write(mem_write_a), .ir_write(ir_write_a),
    .reg_dst(reg_dst_a), .mem_to_reg(mem_to_reg_a), .reg_write(reg_write_a),
    .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .alu_ctrl(alu_ctrl_a),
    .pc_src(pc_src_a), .pc_en(pc_en_a), .trap(trap_a), .state_o(state_a)
  );

  multicycle_control #(.EXT_IMM(1'b0), .MEM_TIMEOUT(4), .CNT_W(5)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord_b), .mem_read(mem_read_b), .mem_write(mem_write_b), .ir_write(ir_write_b),
    .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b),
    .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_ctrl(alu_ctrl_b),
    .pc_src(pc_src_b), .pc_en(pc_en_b), .trap(trap_b), .state_o(state_b)
  );

  wire [20:0] obs_a = {iord_a, mem_read_a, mem_write_a, ir_write_a, reg_dst_a, mem_to_reg_a,
                       reg_write_a, alu_src_a_a, alu_src_b_a, alu_ctrl_a, pc_src_a, pc_en_a,
                       trap_a, state_a};
  wire [20:0] obs_b = {iord_b, mem_read_b, mem_write_b, ir_write_b, reg_dst_b, mem_to_reg_b,
                       reg_write_b, alu_src_a_b, alu_src_b_b, alu_ctrl_b, pc_src_b, pc_en_b,
                       trap_b, state_b};

  typedef struct {
    string      tag;
    logic       rst;
    logic       rdy;
    logic       z;
    logic [5:0] op;
    logic [5:0] funct;
    logic [20:0] ea;
    logic [20:0] eb;
  } step_t;

  step_t      sb_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [5:0] cur_op, cur_funct;
  logic       cur_z;

  localparam logic [2:0] AND_C = 3'b000, OR_C = 3'b001, ADD_C = 3'b010, SUB_C = 3'b110, SLT_C = 3'b111;

  function automatic logic [20:0] mk(input logic [3:0] st, input logic iord_e, mr, mw, irw, rdst,
                                     m2r, rw, sa, input logic [1:0] sbv, input logic [2:0] ac,
                                     input logic [1:0] ps, input logic pe, tr);
    return {iord_e, mr, mw, irw, rdst, m2r, rw, sa, sbv, ac, ps, pe, tr, st};
  endfunction

  function automatic logic [20:0] e_zero();           return 21'd0; endfunction
  function automatic logic [20:0] e_fetch(input logic r);
    return mk(4'd0, 0, 1, 0, r, 0, 0, 0, 0, 2'b01, ADD_C, 2'b00, r, 0);
  endfunction
  function automatic logic [20:0] e_decode();  return mk(4'd1, 0,0,0,0,0,0,0,0, 2'b11, ADD_C, 2'b00, 0, 0); endfunction
  function automatic logic [20:0] e_memadr();  return mk(4'd2, 0,0,0,0,0,0,0,1, 2'b10, ADD_C, 2'b00, 0, 0); endfunction
  function automatic logic [20:0] e_memrd();   return mk(4'd3, 1,1,0,0,0,0,0,0, 2'b00, AND_C, 2'b00, 0, 0); endfunction
  function automatic logic [20:0] e_memwb();   return mk(4'd4, 0,0,0,0,0,1,1,0, 2'b00, AND_C, 2'b00, 0, 0); endfunction
  function automatic logic [20:0] e_memwr();   return mk(4'd5, 1,0,1,0,0,0,0,0, 2'b00, AND_C, 2'b00, 0, 0); endfunction
  function automatic logic [20:0] e_exec(input logic [2:0] ac);
    return mk(4'd6, 0,0,0,0,0,0,0,1, 2'b00, ac, 2'b00, 0, 0);
  endfunction
  function automatic logic [20:0] e_aluwb();   return mk(4'd7, 0,0,0,0,1,0,1,0, 2'b00, AND_C, 2'b00, 0, 0); endfunction
  function automatic logic [20:0] e_branch(input logic z);
    return mk(4'd8, 0,0,0,0,0,0,0,1, 2'b00, SUB_C, 2'b01, z, 0);
  endfunction
  function automatic logic [20:0] e_immex(input logic [2:0] ac);
    return mk(4'd9, 0,0,0,0,0,0,0,1, 2'b10, ac, 2'b00, 0, 0);
  endfunction
  function automatic logic [20:0] e_immwb();   return mk(4'd10, 0,0,0,0,0,0,1,0, 2'b00, AND_C, 2'b00, 0, 0); endfunction
  function automatic logic [20:0] e_jump();    return mk(4'd11, 0,0,0,0,0,0,0,0, 2'b00, AND_C, 2'b10, 1, 0); endfunction
  function automatic logic [20:0] e_trap();    return mk(4'd12, 0,0,0,0,0,0,0,0, 2'b00, AND_C, 2'b00, 0, 1); endfunction

  task automatic check_val(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic rst, input logic rdy, input logic [20:0] ea,
                      input logic [20:0] eb);
    step_t s;
    s.tag = tag; s.rst = rst; s.rdy = rdy; s.z = cur_z;
    s.op = cur_op; s.funct = cur_funct; s.ea = ea; s.eb = eb;
    sb_q.push_back(s);
  endtask

  task automatic cyc2(input string tag, input logic rdy, input logic [20:0] e);
    push(tag, 1'b0, rdy, e, e);
  endtask

  task automatic rst_cyc(input string tag, input logic rdy);
    push(tag, 1'b1, rdy, e_zero(), e_zero());
  endtask

  task automatic run();
    step_t s;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      @(negedge clk);
      reset = s.rst; mem_ready = s.rdy; zero = s.z; op = s.op; funct = s.funct;
      #2;
      check_val({s.tag, "/a"}, obs_a, s.ea);
      check_val({s.tag, "/b"}, obs_b, s.eb);
    end
  endtask

  logic [5:0] r_funct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] r_alu   [5] = '{ADD_C, SUB_C, AND_C, OR_C, SLT_C};
  logic [5:0] i_op    [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
  logic [2:0] i_alu   [4] = '{ADD_C, AND_C, OR_C, SLT_C};

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = '0; funct = '0;
    cur_op = '0; cur_funct = '0; cur_z = 1'b0;

    rst_cyc("reset0", 1'b0); rst_cyc("reset1", 1'b1);
    run();

    for (int i = 0; i < 5; i++) begin
      cur_op = 6'b000000; cur_funct = r_funct[i];
      cyc2("r_fetch", 1, e_fetch(1)); cyc2("r_decode", 1, e_decode());
      cyc2("r_exec", 1, e_exec(r_alu[i])); cyc2("r_aluwb", 1, e_aluwb());
      cyc2("r_fetch2", 1, e_fetch(1)); rst_cyc("r_rst", 0);
      run();
    end

    cur_op = 6'b100011; cur_funct = '0;
    cyc2("lw_fw0", 0, e_fetch(0)); cyc2("lw_fw1", 0, e_fetch(0)); cyc2("lw_fetch", 1, e_fetch(1));
    cyc2("lw_decode", 1, e_decode()); cyc2("lw_memadr", 1, e_memadr());
    cyc2("lw_rdw0", 0, e_memrd()); cyc2("lw_rdw1", 0, e_memrd()); cyc2("lw_memrd", 1, e_memrd());
    cyc2("lw_memwb", 1, e_memwb()); cyc2("lw_fetch2", 1, e_fetch(1)); rst_cyc("lw_rst", 0);
    run();

    cur_op = 6'b101011;
    cyc2("sw_fetch", 1, e_fetch(1)); cyc2("sw_decode", 1, e_decode()); cyc2("sw_memadr", 1, e_memadr());
    cyc2("sw_memwr", 1, e_memwr()); cyc2("sw_fetch2", 1, e_fetch(1)); rst_cyc("sw_rst", 0);
    run();

    for (int z = 1; z >= 0; z--) begin
      cur_op = 6'b000100; cur_z = z[0];
      cyc2("beq_fetch", 1, e_fetch(1)); cyc2("beq_decode", 1, e_decode());
      cyc2("beq_branch", 1, e_branch(z[0])); cyc2("beq_fetch2", 1, e_fetch(1)); rst_cyc("beq_rst", 0);
      run();
    end
    cur_z = 1'b0;

    cur_op = 6'b000010;
    cyc2("j_fetch", 1, e_fetch(1)); cyc2("j_decode", 1, e_decode()); cyc2("j_jump", 1, e_jump());
    cyc2("j_fetch2", 1, e_fetch(1)); rst_cyc("j_rst", 0);
    run();

    for (int i = 0; i < 4; i++) begin
      cur_op = i_op[i];
      cyc2("imm_fetch", 1, e_fetch(1)); cyc2("imm_decode", 1, e_decode());
      if (i == 0) begin
        cyc2("imm_ex", 1, e_immex(i_alu[i])); cyc2("imm_wb", 1, e_immwb()); cyc2("imm_fetch2", 1, e_fetch(1));
      end else begin
        push("ext_ex", 0, 1, e_immex(i_alu[i]), e_trap());
        push("ext_wb", 0, 1, e_immwb(), e_trap());
        push("ext_fetch2", 0, 1, e_fetch(1), e_trap());
      end
      rst_cyc("imm_rst", 0);
      run();
    end

    cur_op = 6'b111111;
    cyc2("ill_fetch", 1, e_fetch(1)); cyc2("ill_decode", 1, e_decode());
    for (int k = 0; k < 10; k++) cyc2("ill_trap", (k % 2 == 0), e_trap());
    rst_cyc("ill_rst", 1); cyc2("ill_after_rst", 1, e_fetch(1)); rst_cyc("ill_rst2", 0);
    run();

    cur_op = 6'b000000; cur_funct = 6'b000000;
    cyc2("badf_fetch", 1, e_fetch(1)); cyc2("badf_decode", 1, e_decode());
    cyc2("badf_trap0", 1, e_trap()); cyc2("badf_trap1", 1, e_trap()); rst_cyc("badf_rst", 0);
    run();

    cur_op = 6'b101011;
    cyc2("to_fetch", 1, e_fetch(1)); cyc2("to_decode", 1, e_decode()); cyc2("to_memadr", 1, e_memadr());
    for (int k = 0; k < 4; k++) cyc2("to_wr_wait", 0, e_memwr());
    push("to_5th", 0, 0, e_memwr(), e_trap());
    push("to_6th", 0, 1, e_memwr(), e_trap());
    push("to_after", 0, 1, e_fetch(1), e_trap());
    rst_cyc("to_rst", 0);
    run();

    cyc2("win_fetch", 1, e_fetch(1)); cyc2("win_decode", 1, e_decode()); cyc2("win_memadr", 1, e_memadr());
    for (int k = 0; k < 3; k++) cyc2("win_wait", 0, e_memwr());
    cyc2("win_last", 1, e_memwr()); cyc2("win_fetch2", 1, e_fetch(1)); rst_cyc("win_rst", 0);
    run();

    for (int k = 0; k < 16; k++) push("fto_wait", 0, 0, e_fetch(0), (k < 4) ? e_fetch(0) : e_trap());
    cyc2("fto_trap", 1, e_trap()); rst_cyc("fto_rst", 0);
    run();

    cyc2("rmw_fetch", 1, e_fetch(1)); cyc2("rmw_decode", 1, e_decode()); cyc2("rmw_memadr", 1, e_memadr());
    cyc2("rmw_memwr", 0, e_memwr()); rst_cyc("rmw_rst", 1); cyc2("rmw_fetch2", 1, e_fetch(1));
    rst_cyc("rmw_rst2", 0);
    run();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
